// File: rtl/vga_timing_ctrl.sv
// Raster timing controller for a VGA pixel path (640x480@60 by default).
// Owns the horizontal/vertical position counters. Decodes sync, blanking and
// start strobes one clock ahead, so every registered output changes on the
// same edge as the counts it describes.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,   // H_TOTAL must not exceed 1024
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,   // V_TOTAL must not exceed 1024
  parameter logic SYNC_POL = 1'b0  // active level of hsync/vsync
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       enable_v,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SY_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
  localparam logic [9:0] V_SY_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FP + V_SYNC);

  // One phase type serves both axes: active, front porch, sync, back porch.
  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_e;

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  phase_e     h_phase_q, h_phase_d;
  phase_e     v_phase_q, v_phase_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  logic h_wrap, v_wrap, line_adv;

  // Phase changes only on the entry counts; in between the phase holds.
  function automatic phase_e next_phase(input phase_e     cur,
                                        input logic [9:0] cnt,
                                        input logic [9:0] fp_start,
                                        input logic [9:0] sy_start,
                                        input logic [9:0] bp_start);
    next_phase = cur;
    if (cnt == 10'd0)         next_phase = PH_ACT;
    else if (cnt == fp_start) next_phase = PH_FP;
    else if (cnt == sy_start) next_phase = PH_SYNC;
    else if (cnt == bp_start) next_phase = PH_BP;
  endfunction

  assign h_wrap   = (h_count_q == H_LAST);
  assign v_wrap   = (v_count_q == V_LAST);
  assign line_adv = pix_en & h_wrap;
  assign enable_v = rst_n & line_adv;

  // Next pixel position: h steps on every pixel tick, v steps when h wraps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (pix_en) h_count_d = h_wrap ? 10'd0 : h_count_q + 10'd1;
    if (line_adv) v_count_d = v_wrap ? 10'd0 : v_count_q + 10'd1;
  end

  // Phases and output decode are taken from the next counts so they land with them.
  always_comb begin
    h_phase_d     = next_phase(h_phase_q, h_count_d, H_FP_START, H_SY_START, H_BP_START);
    v_phase_d     = next_phase(v_phase_q, v_count_d, V_FP_START, V_SY_START, V_BP_START);
    hsync_d       = (h_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (v_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (h_phase_d == PH_ACT) && (v_phase_d == PH_ACT);
    // Strobes are single-clock: they clear on the next clk even without a pixel tick.
    line_start_d  = line_adv;
    frame_start_d = line_adv & v_wrap;
  end

  // State register; reset parks the raster on the last pixel of the frame.
  // NOTE: asynchronous reset lives in the sensitivity list; state uses non-blocking
  // assignments so all flops sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q     <= H_LAST;
      v_count_q     <= V_LAST;
      h_phase_q     <= PH_BP;
      v_phase_q     <= PH_BP;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      h_phase_q     <= h_phase_d;
      v_phase_q     <= v_phase_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
